icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache directly upstream of the instruction-fetch stage.
- Takes a PC request from IF and returns the 32-bit instruction word with a one-cycle success pulse.
- On a miss, refills a whole 4-word line from the memory controller with word-granular requests.
- Flushed responses are suppressed on ROB mispredict (clear) without corrupting the array.

---
 rtl/icache_direct_if.sv | 25 ++
 rtl/icache_direct.sv | 137 +++++++++++++
 tb/tb_icache_direct.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch-side and memory-side signal bundle for icache_direct
interface icache_direct_if;
    logic        rdy;
    logic        clear;
    logic        if_enable;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_success;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;

    // master: the surrounding pipeline and memory controller
    modport master (
        output rdy, clear, if_enable, if_pc, mem_data, mem_done,
        input  if_instr, if_success, mem_req, mem_addr
    );

    // slave: the cache itself
    modport slave (
        input  rdy, clear, if_enable, if_pc, mem_data, mem_done,
        output if_instr, if_success, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache, 4-word lines, word refill
module icache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic           clk,
    input  logic           rst,
    icache_direct_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - 4 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, RESP, DRAIN} state_t;

    state_t                  state;
    logic [31:2]             req_pc;
    logic [1:0]              k;
    logic                    killed;
    logic                    succ_q;
    logic [31:0]             instr_q;
    logic                    req_q;
    logic [31:0]             addr_q;

    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tag_arr  [LINES];
    logic [31:0]             data_arr [LINES][4];
    logic [31:0]             line_buf [4];

    logic [INDEX_BITS-1:0]   pc_index;
    logic [TAG_BITS-1:0]     pc_tag;
    logic [1:0]              pc_off;
    logic [INDEX_BITS-1:0]   req_index;
    logic [TAG_BITS-1:0]     req_tag;
    logic [1:0]              req_off;
    logic                    hit;
    logic                    word_in;
    logic                    install;
    logic [31:0]             fwd_word;
    logic                    unused_pc_bits;

    assign pc_index  = bus.if_pc[3+INDEX_BITS:4];
    assign pc_tag    = bus.if_pc[31:4+INDEX_BITS];
    assign pc_off    = bus.if_pc[3:2];
    assign req_index = req_pc[3+INDEX_BITS:4];
    assign req_tag   = req_pc[31:4+INDEX_BITS];
    assign req_off   = req_pc[3:2];
    assign unused_pc_bits = ^bus.if_pc[1:0];

    assign hit      = valid[pc_index] && (tag_arr[pc_index] == pc_tag);
    assign word_in  = bus.rdy && (state == REFILL) && bus.mem_done;
    assign install  = word_in && (k == 2'd3);
    // On the last beat the requested word may be the one arriving right now.
    assign fwd_word = (req_off == 2'd3) ? bus.mem_data : line_buf[req_off];

    assign bus.if_success = succ_q & ~bus.clear;
    assign bus.if_instr   = instr_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;

    always_ff @(posedge clk) begin
        if (!rst && word_in) begin
            line_buf[k] <= bus.mem_data;
        end
        if (!rst && install) begin
            tag_arr[req_index] <= req_tag;
            for (int w = 0; w < 3; w++) begin
                data_arr[req_index][w] <= line_buf[w];
            end
            data_arr[req_index][3] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            succ_q  <= 1'b0;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            addr_q  <= 32'd0;
            k       <= 2'd0;
            req_pc  <= '0;
            killed  <= 1'b0;
        end else if (bus.rdy) begin
            case (state)
                IDLE: begin
                    if (bus.if_enable && !bus.clear) begin
                        req_pc <= bus.if_pc[31:2];
                        killed <= 1'b0;
                        if (hit) begin
                            state   <= RESP;
                            succ_q  <= 1'b1;
                            instr_q <= data_arr[pc_index][pc_off];
                        end else begin
                            state  <= REFILL;
                            k      <= 2'd0;
                            req_q  <= 1'b1;
                            addr_q <= {bus.if_pc[31:4], 4'b0000};
                        end
                    end
                end
                REFILL: begin
                    // A flush never aborts the transfer; it only suppresses the response.
                    if (bus.clear) begin
                        killed <= 1'b1;
                    end
                    if (bus.mem_done) begin
                        if (k != 2'd3) begin
                            k      <= k + 2'd1;
                            addr_q <= addr_q + 32'd4;
                        end else begin
                            req_q            <= 1'b0;
                            valid[req_index] <= 1'b1;
                            if (killed || bus.clear) begin
                                state <= DRAIN;
                            end else begin
                                state   <= RESP;
                                succ_q  <= 1'b1;
                                instr_q <= fwd_word;
                            end
                        end
                    end
                end
                RESP: begin
                    succ_q <= 1'b0;
                    state  <= IDLE;
                end
                DRAIN: begin
                    succ_q  <= 1'b0;
                    instr_q <= 32'd0;
                    killed  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct with a latency-2 memory model
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_direct_if bus();

    icache_direct #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        int          exp_cyc;   // -1: one cycle after the last mem_done
    } resp_t;

    resp_t       resp_q[$];
    logic [31:0] addr_q[$];

    int          checks        = 0;
    int          failures      = 0;
    int          cyc           = 0;
    int          done_cnt      = 0;
    int          last_done_cyc = 0;
    int          mem_accepts   = 0;
    int          mem_cnt       = 0;
    logic [31:0] cur_addr      = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'h11 * ({28'd0, a[3:2]} + 32'd1);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor
    initial forever begin
        @(negedge clk);
        if (bus.if_success === 1'b1) begin
            if (resp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=instr %h required=no response", bus.if_instr);
            end else begin
                resp_t r;
                int    ec;
                r  = resp_q.pop_front();
                ec = (r.exp_cyc < 0) ? last_done_cyc + 1 : r.exp_cyc;
                check("resp_instr", bus.if_instr, r.instr);
                check("resp_cycle", cyc, ec);
            end
        end
    end

    // Memory controller model: accepts a request, answers two rdy cycles later
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                mem_cnt      = 0;
                bus.mem_done = 1'b0;
            end else begin
                if (bus.mem_done) bus.mem_done = 1'b0;
                if (mem_cnt > 0) begin
                    if (bus.rdy) begin
                        mem_cnt--;
                        if (mem_cnt == 0) begin
                            check("mem_addr_hold", bus.mem_addr, cur_addr);
                            bus.mem_done  = 1'b1;
                            bus.mem_data  = mem_word(cur_addr);
                            done_cnt++;
                            last_done_cyc = cyc;
                        end
                    end
                end else if (bus.mem_req && bus.rdy) begin
                    mem_accepts++;
                    cur_addr = bus.mem_addr;
                    if (addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_mem_req actual=addr %h required=no request", bus.mem_addr);
                    end else begin
                        check("mem_addr", bus.mem_addr, addr_q.pop_front());
                    end
                    mem_cnt = 2;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc);
        bus.if_enable = 1'b1;
        bus.if_pc     = pc;
        step();
        bus.if_enable = 1'b0;
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
    endtask

    task automatic push_resp(input logic [31:0] instr, input int exp_cyc);
        resp_t r;
        r.instr   = instr;
        r.exp_cyc = exp_cyc;
        resp_q.push_back(r);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 100 && resp_q.size() != 0; i++) step();
        check("resp_wait", resp_q.size(), 0);
        resp_q.delete();
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100 && done_cnt < target; i++) step();
        check("done_wait", 32'(done_cnt >= target), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int t;
        rst           = 1'b1;
        bus.rdy       = 1'b1;
        bus.clear     = 1'b0;
        bus.if_enable = 1'b0;
        bus.if_pc     = 32'd0;
        step(); step(); step();
        check("rst_success", bus.if_success, 0);
        check("rst_instr",   bus.if_instr,   0);
        check("rst_mem_req", bus.mem_req,    0);
        check("rst_mem_addr", bus.mem_addr,  0);
        rst = 1'b0;
        step();

        // Cold miss at 0x8
        push_line(32'h0);
        push_resp(32'h33, -1);
        issue(32'h8);
        wait_resp();
        check("cold_addrs_left", addr_q.size(), 0);

        // Hit at 0xC, then 0x0 two cycles after that pulse
        a = mem_accepts;
        t = cyc;
        push_resp(32'h44, t + 1);
        push_resp(32'h11, t + 3);
        bus.if_enable = 1'b1;
        bus.if_pc     = 32'hC;
        step();
        bus.if_pc     = 32'h0;
        step();
        step();
        bus.if_enable = 1'b0;
        wait_resp();
        check("hit_no_mem", mem_accepts, a);

        // Conflict eviction at index 0
        push_line(32'h400);
        push_resp(32'hC0DE0400, -1);
        issue(32'h400);
        wait_resp();
        push_line(32'h0);
        push_resp(32'h11, -1);
        issue(32'h0);
        wait_resp();
        check("evict_addrs_left", addr_q.size(), 0);

        // Clear after the 2nd beat of a refill at 0x20
        a = done_cnt;
        push_line(32'h20);
        issue(32'h20);
        wait_done(a + 2);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        wait_done(a + 4);
        step();
        step();
        check("kill_addrs_left", addr_q.size(), 0);
        check("kill_mem_req", bus.mem_req, 0);
        a = mem_accepts;
        push_resp(32'hC0DE0020, cyc + 1);
        issue(32'h20);
        wait_resp();
        check("kill_hit_no_mem", mem_accepts, a);

        // Clear while the response is on the bus
        issue(32'h24);
        bus.clear = 1'b1;
        #1;
        check("resp_clear_gate", bus.if_success, 0);
        step();
        bus.clear = 1'b0;
        step();

        // Clear has priority over a simultaneous fetch
        a = mem_accepts;
        bus.clear = 1'b1;
        issue(32'h300);
        bus.clear = 1'b0;
        step();
        step();
        check("clear_prio_no_mem", mem_accepts, a);
        check("clear_prio_req", bus.mem_req, 0);

        // rdy stall at k=1 of a refill at 0x40
        a = done_cnt;
        push_line(32'h40);
        push_resp(32'hC0DE0044, -1);
        issue(32'h44);
        wait_done(a + 1);
        bus.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_addr", bus.mem_addr, 32'h44);
            check("stall_req",  bus.mem_req,  1);
        end
        bus.rdy = 1'b1;
        wait_resp();
        check("stall_addrs_left", addr_q.size(), 0);

        // Reset at k=2 of a refill at 0x80
        a = done_cnt;
        addr_q.push_back(32'h80);
        addr_q.push_back(32'h84);
        issue(32'h84);
        wait_done(a + 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_mem_req", bus.mem_req, 0);
        check("rstmid_success", bus.if_success, 0);
        step();
        push_line(32'h0);
        push_resp(32'h44, -1);
        issue(32'hC);
        wait_resp();
        check("final_addrs_left", addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
